// File: rtl/hc595_frame_rx.sv
// Receive side of a 74HC595 serial display link: synchronises shcp/stcp/ds/oe,
// rebuilds the {seg,sel} frame and flags short/long frames and stalled shift clocks.
module hc595_frame_rx #(
    parameter int SEL_W   = 6,
    parameter int SEG_W   = 8,
    parameter int FRAME_W = SEL_W + SEG_W,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shcp,
    input  logic             stcp,
    input  logic             ds,
    input  logic             oe,
    output logic [SEL_W-1:0] sel,
    output logic [SEG_W-1:0] seg,
    output logic             frame_vld,
    output logic             frame_err,
    output logic             timeout,
    output logic             blank,
    output logic [4:0]       bit_cnt
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    // bit order in the sync vectors: [3]=oe, [2]=ds, [1]=stcp, [0]=shcp
    logic [3:0]         r_s1;
    logic [3:0]         r_s2;
    logic [2:0]         r_s3;
    logic [FRAME_W-1:0] r_sr;
    logic [FRAME_W-1:0] w_sr_nxt;
    logic [4:0]         r_bit_cnt;
    logic [4:0]         w_bit_cnt_nxt;
    logic [TW-1:0]      r_tcnt;
    logic [TW-1:0]      w_tcnt_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [SEG_W-1:0]   r_seg;
    logic [SEG_W-1:0]   w_seg_nxt;
    logic               r_vld;
    logic               w_vld_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               r_to;
    logic               w_to_nxt;
    logic               w_shcp_rise;
    logic               w_stcp_rise;
    logic               w_ds;

    assign w_shcp_rise = r_s2[0] & ~r_s3[0];
    assign w_stcp_rise = r_s2[1] & ~r_s3[1];
    // ds one stage behind shcp_s2: the data level present before the shift edge
    assign w_ds        = r_s3[2];

    assign sel       = r_sel;
    assign seg       = r_seg;
    assign frame_vld = r_vld;
    assign frame_err = r_err;
    assign timeout   = r_to;
    assign blank     = r_s2[3];
    assign bit_cnt   = r_bit_cnt;

    // Input synchroniser chain plus edge-history stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 4'b0000;
            r_s2 <= 4'b0000;
            r_s3 <= 3'b000;
        end else begin
            r_s1 <= {oe, ds, stcp, shcp};
            r_s2 <= r_s1;
            r_s3 <= r_s2[2:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, shift, latch and stall-timeout decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_sr_nxt      = r_sr;
        w_bit_cnt_nxt = r_bit_cnt;
        w_tcnt_nxt    = r_tcnt;
        w_sel_nxt     = r_sel;
        w_seg_nxt     = r_seg;
        w_vld_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_to_nxt      = 1'b0;

        if (w_shcp_rise) begin
            w_sr_nxt      = {w_ds, r_sr[FRAME_W-1:1]};
            w_bit_cnt_nxt = (r_bit_cnt == 5'd31) ? 5'd31 : r_bit_cnt + 5'd1;
            w_tcnt_nxt    = {TW{1'b0}};
        end else begin
            w_sr_nxt = r_sr;
        end

        // Latch judges the pre-shift frame; a coincident shift starts the next one.
        if (w_stcp_rise) begin
            if (r_bit_cnt == 5'(FRAME_W)) begin
                w_sel_nxt = r_sr[SEL_W-1:0];
                w_seg_nxt = r_sr[FRAME_W-1:SEL_W];
                w_vld_nxt = 1'b1;
            end else begin
                w_err_nxt = 1'b1;
            end
            w_bit_cnt_nxt = w_shcp_rise ? 5'd1 : 5'd0;
        end else begin
            w_err_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                w_tcnt_nxt = {TW{1'b0}};
                if (w_shcp_rise) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_stcp_rise) begin
                    w_state_nxt = w_shcp_rise ? ST_SHIFT : ST_IDLE;
                    w_tcnt_nxt  = {TW{1'b0}};
                end else if (w_shcp_rise) begin
                    w_state_nxt = ST_SHIFT;
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_to_nxt      = 1'b1;
                    w_bit_cnt_nxt = 5'd0;
                    w_tcnt_nxt    = {TW{1'b0}};
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered output pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr      <= {FRAME_W{1'b0}};
            r_bit_cnt <= 5'd0;
            r_tcnt    <= {TW{1'b0}};
            r_sel     <= {SEL_W{1'b0}};
            r_seg     <= {SEG_W{1'b0}};
            r_vld     <= 1'b0;
            r_err     <= 1'b0;
            r_to      <= 1'b0;
        end else begin
            r_sr      <= w_sr_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_sel     <= w_sel_nxt;
            r_seg     <= w_seg_nxt;
            r_vld     <= w_vld_nxt;
            r_err     <= w_err_nxt;
            r_to      <= w_to_nxt;
        end
    end

endmodule
